// File: rtl/bus_pkg.sv
// Shared types for the system-bus host arbiter and address decoder.
package bus_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Width of a host index; never zero so single-bit ports stay legal.
    function automatic int host_idx_w(input int nr_hosts);
        return (nr_hosts > 1) ? $clog2(nr_hosts) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first candidate at or after the pointer, wrapping.
module rr_pick
    import bus_pkg::*;
#(
    parameter int NrHosts = 2,
    parameter int IdxW    = host_idx_w(NrHosts)
) (
    input  logic [NrHosts-1:0] i_req,
    input  logic [IdxW-1:0]    i_ptr,
    input  logic [NrHosts-1:0] i_excl,
    output logic [NrHosts-1:0] o_gnt,
    output logic [IdxW-1:0]    o_idx,
    output logic               o_valid
);

    logic [NrHosts-1:0] w_cand;
    logic [IdxW-1:0]    w_k;

    assign w_cand = i_req & ~i_excl;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_k     = '0;
        for (int i = 0; i < NrHosts; i++) begin
            w_k = IdxW'((int'(i_ptr) + i) % NrHosts);
            if (!o_valid && w_cand[w_k]) begin
                o_valid    = 1'b1;
                o_idx      = w_k;
                o_gnt[w_k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter with bounded bus lock sharing one system bus between several hosts;
// read data returns one cycle after the grant to the host that owned the request.
module bus_host_arbiter
    import bus_pkg::*;
#(
    parameter int NrHosts      = 2,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32,
    parameter int MaxHold      = 4,
    localparam int IdxW        = host_idx_w(NrHosts)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NrHosts-1:0]              host_req_i,
    input  logic [NrHosts-1:0]              host_lock_i,
    input  logic [NrHosts*AddressWidth-1:0] host_addr_i,
    input  logic [NrHosts-1:0]              host_we_i,
    input  logic [NrHosts*DataWidth-1:0]    host_wdata_i,
    output logic [NrHosts-1:0]              host_gnt_o,
    output logic [NrHosts-1:0]              host_rvalid_o,
    output logic [DataWidth-1:0]            host_rdata_o,
    output logic                            bus_req_o,
    output logic [AddressWidth-1:0]         bus_addr_o,
    output logic                            bus_we_o,
    output logic [DataWidth-1:0]            bus_wdata_o,
    input  logic [DataWidth-1:0]            bus_rdata_i,
    output arb_state_e                      o_dbg_state,
    output logic [IdxW-1:0]                 o_dbg_rr_ptr
);

    localparam int HoldW = $clog2(MaxHold + 1);

    arb_state_e          r_state, w_state_nxt;
    logic [IdxW-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [IdxW-1:0]     r_lock_owner, w_lock_owner_nxt;
    logic [HoldW-1:0]    r_hold_cnt, w_hold_cnt_nxt;
    logic [IdxW-1:0]     r_owner_q;
    logic                r_pend_q;

    logic [NrHosts-1:0]  w_owner_oh, w_excl, w_pick_gnt, w_gnt;
    logic [IdxW-1:0]     w_pick_idx, w_winner;
    logic                w_pick_valid, w_any_req, w_owner_active;
    logic                w_hold_full, w_others_req, w_force_rot;

    // Reset gates the combinational grant path so outputs drop immediately.
    assign w_any_req      = rst_i & (|host_req_i);
    assign w_owner_active = (r_state == ARB_LOCKED) && host_req_i[r_lock_owner] && host_lock_i[r_lock_owner];
    assign w_hold_full    = (r_hold_cnt == HoldW'(MaxHold));
    assign w_others_req   = |(host_req_i & ~w_owner_oh);
    assign w_force_rot    = w_owner_active & w_hold_full & w_others_req;
    assign w_excl         = w_force_rot ? w_owner_oh : '0;

    always_comb begin
        w_owner_oh               = '0;
        w_owner_oh[r_lock_owner] = 1'b1;
    end

    rr_pick #(
        .NrHosts (NrHosts),
        .IdxW    (IdxW)
    ) u_rr_pick (
        .i_req   (host_req_i),
        .i_ptr   (r_rr_ptr),
        .i_excl  (w_excl),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= ARB_IDLE;
            r_rr_ptr     <= '0;
            r_lock_owner <= '0;
            r_hold_cnt   <= '0;
            r_owner_q    <= '0;
            r_pend_q     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_lock_owner <= w_lock_owner_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_owner_q    <= w_winner;
            r_pend_q     <= bus_req_o & ~bus_we_o;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_rr_ptr_nxt     = r_rr_ptr;
        w_lock_owner_nxt = r_lock_owner;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_gnt            = '0;
        w_winner         = '0;
        if (w_any_req) begin
            if (w_owner_active && !w_force_rot) begin
                // Lock owner keeps the bus; pointer stays frozen while locked.
                w_gnt          = w_owner_oh;
                w_winner       = r_lock_owner;
                w_hold_cnt_nxt = w_hold_full ? HoldW'(1) : r_hold_cnt + 1'b1;
            end else if (w_pick_valid) begin
                w_gnt        = w_pick_gnt;
                w_winner     = w_pick_idx;
                w_rr_ptr_nxt = (w_pick_idx == IdxW'(NrHosts - 1)) ? '0 : w_pick_idx + 1'b1;
                if (host_lock_i[w_pick_idx]) begin
                    w_state_nxt      = ARB_LOCKED;
                    w_lock_owner_nxt = w_pick_idx;
                    w_hold_cnt_nxt   = HoldW'(1);
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
        end
    end

    assign host_gnt_o  = w_gnt;
    assign bus_req_o   = w_any_req;
    assign bus_we_o    = w_any_req & host_we_i[w_winner];
    assign bus_addr_o  = w_any_req ? host_addr_i[w_winner*AddressWidth +: AddressWidth] : '0;
    assign bus_wdata_o = w_any_req ? host_wdata_i[w_winner*DataWidth +: DataWidth] : '0;

    always_comb begin
        host_rvalid_o = '0;
        if (r_pend_q) begin
            host_rvalid_o[r_owner_q] = 1'b1;
        end
    end

    assign host_rdata_o = r_pend_q ? bus_rdata_i : '0;

    assign o_dbg_state  = r_state;
    assign o_dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Directed bench for bus_host_arbiter with a small bus memory model and a MaxHold=1 twin.
module tb_bus_host_arbiter;
    import bus_pkg::*;

    localparam logic [31:0] RD_A = 32'h1234_5678;
    localparam logic [31:0] RD_B = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, lock, we;
    logic [63:0] addr, wdata;

    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata, bus_addr, bus_wdata, mem_rdata;
    logic        bus_req, bus_we;
    arb_state_e  dbg_state;
    logic        dbg_ptr;

    logic [1:0]  gnt_m1, rvalid_m1;
    logic [31:0] rdata_m1, bus_addr_m1, bus_wdata_m1;
    logic        bus_req_m1, bus_we_m1;
    arb_state_e  dbg_state_m1;
    logic        dbg_ptr_m1;

    logic [31:0] mem [256];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bus_host_arbiter #(.NrHosts(2), .DataWidth(32), .AddressWidth(32), .MaxHold(4)) dut (
        .clk_i(clk), .rst_i(rst_n), .host_req_i(req), .host_lock_i(lock), .host_addr_i(addr),
        .host_we_i(we), .host_wdata_i(wdata), .host_gnt_o(gnt), .host_rvalid_o(rvalid),
        .host_rdata_o(rdata), .bus_req_o(bus_req), .bus_addr_o(bus_addr), .bus_we_o(bus_we),
        .bus_wdata_o(bus_wdata), .bus_rdata_i(mem_rdata), .o_dbg_state(dbg_state), .o_dbg_rr_ptr(dbg_ptr)
    );

    bus_host_arbiter #(.NrHosts(2), .DataWidth(32), .AddressWidth(32), .MaxHold(1)) dut_mh1 (
        .clk_i(clk), .rst_i(rst_n), .host_req_i(req), .host_lock_i(lock), .host_addr_i(addr),
        .host_we_i(we), .host_wdata_i(wdata), .host_gnt_o(gnt_m1), .host_rvalid_o(rvalid_m1),
        .host_rdata_o(rdata_m1), .bus_req_o(bus_req_m1), .bus_addr_o(bus_addr_m1), .bus_we_o(bus_we_m1),
        .bus_wdata_o(bus_wdata_m1), .bus_rdata_i(mem_rdata), .o_dbg_state(dbg_state_m1), .o_dbg_rr_ptr(dbg_ptr_m1)
    );

    // Bus memory: write lands at the edge, read data appears the cycle after the request.
    always @(posedge clk) begin
        if (bus_req) begin
            if (bus_we) mem[bus_addr[9:2]] <= bus_wdata;
            else        mem_rdata <= mem[bus_addr[9:2]];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int h, input logic r, input logic l, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        req[h]            = r;
        lock[h]           = l;
        we[h]             = w;
        addr[h*32 +: 32]  = a;
        wdata[h*32 +: 32] = d;
    endtask

    task automatic clear_all();
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] prev);
        return (prev == 2'b01) ? RD_A : (prev == 2'b10) ? RD_B : 32'h0;
    endfunction

    logic [1:0] e_main [8] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01};
    logic [1:0] e_mh1  [8] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] prev;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = RD_A;
        mem_rdata  = 32'h0;
        rst_n = 1'b0;
        clear_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", gnt, 2'b00);
        check("rst_rvalid", rvalid, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_bus_we", bus_we, 1'b0);
        check("rst_state", dbg_state, ARB_IDLE);
        check("rst_ptr", dbg_ptr, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single host read
        drive(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        check("single_gnt", gnt, 2'b01);
        check("single_bus_req", bus_req, 1'b1);
        check("single_addr", bus_addr, 32'h100);
        check("single_we", bus_we, 1'b0);
        adv();
        clear_all();
        @(negedge clk);
        check("single_rvalid", rvalid, 2'b01);
        check("single_rdata", rdata, RD_A);
        check("single_idle_req", bus_req, 1'b0);
        adv();

        // Write by host0, read-back by host1 next cycle
        drive(0, 1'b1, 1'b0, 1'b1, 32'h200, RD_B);
        @(negedge clk);
        check("mix_wr_gnt", gnt, 2'b01);
        check("mix_wr_we", bus_we, 1'b1);
        check("mix_wr_wdata", bus_wdata, RD_B);
        adv();
        clear_all();
        drive(1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
        @(negedge clk);
        check("mix_rd_gnt", gnt, 2'b10);
        check("mix_wr_no_rvalid", rvalid, 2'b00);
        check("mix_rd_addr", bus_addr, 32'h200);
        adv();
        clear_all();
        @(negedge clk);
        check("mix_rd_rvalid", rvalid, 2'b10);
        check("mix_rd_rdata", rdata, RD_B);
        adv();

        // Plain contention: strict alternation, responses one cycle behind
        drive(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
        prev = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("rr_gnt%0d", i), gnt, (i % 2 == 1) ? 2'b10 : 2'b01);
            check($sformatf("rr_rvalid%0d", i), rvalid, prev);
            check($sformatf("rr_rdata%0d", i), rdata, exp_rd(prev));
            prev = (i % 2 == 1) ? 2'b10 : 2'b01;
            adv();
        end
        clear_all();
        @(negedge clk);
        check("rr_rvalid_tail", rvalid, prev);
        check("rr_rdata_tail", rdata, exp_rd(prev));
        adv();

        // Lock by host1 for three grants, host0 waiting
        drive(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        @(negedge clk);
        check("lk_pre_gnt", gnt, 2'b01);
        adv();
        drive(1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("lk_gnt%0d", i), gnt, 2'b10);
            check($sformatf("lk_state%0d", i), dbg_state, (i == 0) ? ARB_IDLE : ARB_LOCKED);
            check($sformatf("lk_ptr%0d", i), dbg_ptr, (i == 0) ? 1'b1 : 1'b0);
            adv();
        end
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("lk_exit_gnt", gnt, 2'b01);
        check("lk_exit_ptr", dbg_ptr, 1'b0);
        adv();
        clear_all();
        @(negedge clk);
        check("lk_after_state", dbg_state, ARB_IDLE);
        check("lk_after_ptr", dbg_ptr, 1'b1);
        adv();

        // Reset in the middle of a host1 read
        drive(1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
        @(negedge clk);
        check("mr_gnt", gnt, 2'b10);
        adv();
        rst_n = 1'b0;
        #1;
        check("mr_rst_gnt", gnt, 2'b00);
        check("mr_rst_bus_req", bus_req, 1'b0);
        check("mr_rst_bus_we", bus_we, 1'b0);
        check("mr_rst_rvalid", rvalid, 2'b00);
        check("mr_rst_rdata", rdata, 32'h0);
        clear_all();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("mr_rel_rvalid", rvalid, 2'b00);
        check("mr_rel_state", dbg_state, ARB_IDLE);
        check("mr_rel_ptr", dbg_ptr, 1'b0);
        adv();

        // Continuous lock by host0 against host1: MaxHold=4 vs MaxHold=1
        drive(0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0);
        prev = 2'b00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("mh4_gnt%0d", i), gnt, e_main[i]);
            check($sformatf("mh1_gnt%0d", i), gnt_m1, e_mh1[i]);
            check($sformatf("mh4_rvalid%0d", i), rvalid, prev);
            prev = e_main[i];
            adv();
        end
        clear_all();
        @(negedge clk);
        check("mh4_rvalid_tail", rvalid, prev);
        adv();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
